// File: rtl/cart_header_checker_if.sv
// Bundle between the header checker and its environment (the requester and the cartridge bus).
// The master side drives the request and the cartridge data; the slave side is the checker.
interface cart_header_checker_if;
    logic         verification_req;
    logic         check_title;
    logic         check_checksum;
    logic [127:0] expected_title;
    logic [7:0]   cart_data;
    logic         cart_rd;
    logic [15:0]  cart_addr;
    logic         verifying;
    logic         verification_complete;
    logic         verification_passed;
    logic         title_mismatch;
    logic         checksum_mismatch;
    logic [7:0]   computed_checksum;

    modport master (
        output verification_req, check_title, check_checksum, expected_title, cart_data,
        input  cart_rd, cart_addr, verifying, verification_complete, verification_passed,
               title_mismatch, checksum_mismatch, computed_checksum
    );

    modport slave (
        input  verification_req, check_title, check_checksum, expected_title, cart_data,
        output cart_rd, cart_addr, verifying, verification_complete, verification_passed,
               title_mismatch, checksum_mismatch, computed_checksum
    );
endinterface

// File: rtl/cart_header_checker.sv
// Reads the cartridge header byte by byte through a slow bus and checks the title
// and/or the header checksum, reporting a held pass/fail result.
module cart_header_checker #(
    parameter int          TITLE_LEN   = 13,
    parameter int          READ_WAIT   = 63,
    parameter logic [15:0] HEADER_BASE = 16'h0134
) (
    input  logic                  clk,
    input  logic                  reset,
    cart_header_checker_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

    localparam logic [4:0] CSUM_OFF  = 5'd25;
    localparam logic [4:0] TITLE_END = 5'(TITLE_LEN);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_req_prev;
    logic         r_arm;
    logic         r_mode_title;
    logic         r_mode_cs;
    logic [127:0] r_exp_title;
    logic [4:0]   r_offset;
    logic [7:0]   r_cnt;
    logic [7:0]   r_cs;
    logic         r_tm;
    logic         r_cm;

    logic         w_accept;
    logic         w_sample;
    logic         w_in_title;
    logic [7:0]   w_title_byte;
    logic         w_title_bad;
    logic [4:0]   w_last_off;
    logic         w_last;
    logic         w_busy;

    function automatic logic [7:0] checksum_step(input logic [7:0] acc, input logic [7:0] data);
        return acc - data - 8'd1;
    endfunction

    // r_arm keeps a request held high across reset release from looking like an edge
    assign w_accept     = bus.verification_req & ~r_req_prev & r_arm &
                          ((r_state == IDLE) || (r_state == DONE));
    assign w_sample     = (r_state == WAIT) && (r_cnt == 8'd0);
    assign w_in_title   = r_mode_title && (r_offset < TITLE_END);
    assign w_title_byte = r_exp_title[{r_offset[3:0], 3'b000} +: 8];
    assign w_title_bad  = w_in_title && (bus.cart_data != w_title_byte);
    assign w_last_off   = r_mode_cs ? CSUM_OFF : 5'(TITLE_LEN - 1);
    assign w_last       = (r_offset == w_last_off);
    assign w_busy       = (r_state == READ) || (r_state == WAIT);

    assign bus.verifying             = w_busy;
    assign bus.cart_rd               = w_busy;
    assign bus.cart_addr             = w_busy ? (HEADER_BASE + {11'd0, r_offset}) : 16'h0000;
    assign bus.verification_complete = (r_state == DONE);
    assign bus.verification_passed   = (r_state == DONE) & ~r_tm & ~r_cm;
    assign bus.title_mismatch        = r_tm;
    assign bus.checksum_mismatch     = r_cm;
    assign bus.computed_checksum     = r_cs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_nxt = (bus.check_title | bus.check_checksum) ? READ : DONE;
                end
            end
            READ: w_state_nxt = WAIT;
            WAIT: begin
                // title-only runs stop at the first bad byte; checksum runs read the full header
                if (w_sample) begin
                    if (w_last || (w_title_bad && !r_mode_cs)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_prev   <= 1'b0;
            r_arm        <= 1'b0;
            r_mode_title <= 1'b0;
            r_mode_cs    <= 1'b0;
            r_exp_title  <= '0;
            r_offset     <= 5'd0;
            r_cnt        <= 8'd0;
            r_cs         <= 8'd0;
            r_tm         <= 1'b0;
            r_cm         <= 1'b0;
        end else begin
            r_req_prev <= bus.verification_req;
            r_arm      <= 1'b1;
            if (w_accept) begin
                r_mode_title <= bus.check_title;
                r_mode_cs    <= bus.check_checksum;
                r_exp_title  <= bus.expected_title;
                r_offset     <= 5'd0;
                r_cnt        <= 8'd0;
                r_cs         <= 8'd0;
                r_tm         <= 1'b0;
                r_cm         <= 1'b0;
            end else if (r_state == READ) begin
                r_cnt <= 8'(READ_WAIT);
            end else if (r_state == WAIT) begin
                if (r_cnt != 8'd0) begin
                    r_cnt <= r_cnt - 8'd1;
                end else begin
                    r_offset <= r_offset + 5'd1;
                    if (w_title_bad) begin
                        r_tm <= 1'b1;
                    end
                    if (r_mode_cs) begin
                        if (r_offset < CSUM_OFF) begin
                            r_cs <= checksum_step(r_cs, bus.cart_data);
                        end else if (r_cs != bus.cart_data) begin
                            r_cm <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cart_header_checker.sv
// Directed bench for cart_header_checker: a header ROM model, a result model computed from
// the header contents, and one compare process checking the outputs every cycle.
module tb_cart_header_checker;

    localparam int          TL   = 13;
    localparam int          RW   = 63;
    localparam int          P    = RW + 2;
    localparam logic [15:0] BASE = 16'h0134;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cart_header_checker_if ifc();

    cart_header_checker #(
        .TITLE_LEN   (TL),
        .READ_WAIT   (RW),
        .HEADER_BASE (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    logic [7:0]  rom [0:25];
    logic [15:0] rom_off;
    assign rom_off       = ifc.cart_addr - BASE;
    assign ifc.cart_data = (rom_off < 16'd26) ? rom[rom_off[4:0]] : 8'hFF;

    // stimulus-owned expectations
    int         s_mode = 2;
    int         s_gen  = 0;
    int         e_n    = 0;
    logic       e_tm   = 1'b0;
    logic       e_cm   = 1'b0;
    logic [7:0] e_cs   = 8'h00;
    logic       e_pass = 1'b0;
    int         pin_t  = -10;
    logic       pin_pass, pin_tm, pin_cm, pin_cs_en;
    logic [7:0] pin_cs;

    // model-owned time since the accepting edge
    int m_gen = 0;
    int m_t   = 0;

    int n_total = 0;
    int n_bad   = 0;

    always @(posedge clk) begin
        if (s_gen != m_gen) begin
            m_gen = s_gen;
            m_t   = 0;
        end else begin
            m_t = m_t + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            if (n_bad < 40) $display("FAIL %s at t=%0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        #1;
        if (s_mode == 1) begin
            if (m_t < e_n * P) begin
                chk("verifying", 32'(ifc.verifying), 32'd1);
                chk("cart_rd", 32'(ifc.cart_rd), 32'd1);
                chk("cart_addr", 32'(ifc.cart_addr), 32'(BASE) + 32'(m_t / P));
                chk("complete_busy", 32'(ifc.verification_complete), 32'd0);
            end else begin
                chk("verifying_done", 32'(ifc.verifying), 32'd0);
                chk("cart_rd_done", 32'(ifc.cart_rd), 32'd0);
                chk("complete", 32'(ifc.verification_complete), 32'd1);
                chk("passed", 32'(ifc.verification_passed), 32'(e_pass));
                chk("title_mismatch", 32'(ifc.title_mismatch), 32'(e_tm));
                chk("checksum_mismatch", 32'(ifc.checksum_mismatch), 32'(e_cm));
                chk("computed_checksum", 32'(ifc.computed_checksum), 32'(e_cs));
            end
            if (m_t == pin_t - 1) chk("pin_complete_early", 32'(ifc.verification_complete), 32'd0);
            if (m_t == pin_t) begin
                chk("pin_complete", 32'(ifc.verification_complete), 32'd1);
                chk("pin_passed", 32'(ifc.verification_passed), 32'(pin_pass));
                chk("pin_title_mismatch", 32'(ifc.title_mismatch), 32'(pin_tm));
                chk("pin_checksum_mismatch", 32'(ifc.checksum_mismatch), 32'(pin_cm));
                if (pin_cs_en) chk("pin_checksum", 32'(ifc.computed_checksum), 32'(pin_cs));
            end
        end else if (s_mode == 2) begin
            chk("idle_verifying", 32'(ifc.verifying), 32'd0);
            chk("idle_cart_rd", 32'(ifc.cart_rd), 32'd0);
            chk("idle_cart_addr", 32'(ifc.cart_addr), 32'd0);
            chk("idle_complete", 32'(ifc.verification_complete), 32'd0);
            chk("idle_passed", 32'(ifc.verification_passed), 32'd0);
            chk("idle_title_mismatch", 32'(ifc.title_mismatch), 32'd0);
            chk("idle_checksum_mismatch", 32'(ifc.checksum_mismatch), 32'd0);
            chk("idle_checksum", 32'(ifc.computed_checksum), 32'd0);
        end
    end

    // Result from the header contents: reads issued, flags and the final checksum.
    task automatic model(input logic t, input logic c, input logic [127:0] title);
        int sum;
        e_n  = 0;
        e_tm = 1'b0;
        e_cm = 1'b0;
        e_cs = 8'h00;
        if (t || c) begin
            e_n = c ? 26 : TL;
            if (t) begin
                for (int i = 0; i < TL; i++) begin
                    if (rom[i] != title[8*i +: 8]) begin
                        if (!e_tm && !c) e_n = i + 1;
                        e_tm = 1'b1;
                    end
                end
            end
            if (c) begin
                sum = 0;
                for (int i = 0; i < 25; i++) sum = sum + int'(rom[i]);
                e_cs = 8'((25600 - sum - 25) % 256);
                e_cm = (e_cs != rom[25]);
            end
        end
        e_pass = !e_tm && !e_cm;
    endtask

    task automatic run_seq(input logic t, input logic c, input logic [127:0] title,
                           input int p_t, input logic p_pass, input logic p_tm, input logic p_cm,
                           input logic p_cs_en, input logic [7:0] p_cs,
                           input int glitch, input int abort_at);
        int  cyc;
        logic stop;
        @(negedge clk);
        model(t, c, title);
        pin_t     = p_t;
        pin_pass  = p_pass;
        pin_tm    = p_tm;
        pin_cm    = p_cm;
        pin_cs_en = p_cs_en;
        pin_cs    = p_cs;
        ifc.check_title    = t;
        ifc.check_checksum = c;
        ifc.expected_title = title;
        ifc.verification_req = 1'b1;
        s_gen  = s_gen + 1;
        s_mode = 1;
        cyc  = 0;
        stop = 1'b0;
        while (!stop) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (glitch != 0 && cyc == 100) ifc.verification_req = 1'b0;
            if (glitch != 0 && cyc == 102) ifc.verification_req = 1'b1;
            if (abort_at != 0 && cyc == abort_at) stop = 1'b1;
            if (abort_at == 0 && ifc.verification_complete) stop = 1'b1;
            if (cyc >= 4000) begin
                $display("FAIL completion_timeout: actual=no_complete required=complete within 4000 cycles");
                $fatal(1, "timeout");
            end
        end
        if (abort_at == 0) begin
            repeat (3) @(negedge clk);
            ifc.verification_req = 1'b0;
        end
    endtask

    task automatic load_rom(input string s);
        for (int i = 0; i < 26; i++) rom[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) rom[i] = s[i];
    endtask

    logic [127:0] title_gb;
    string        gb = "GAMEBOYCAMERA";

    initial begin
        ifc.verification_req = 1'b0;
        ifc.check_title      = 1'b0;
        ifc.check_checksum   = 1'b0;
        ifc.expected_title   = '0;
        title_gb = '0;
        for (int i = 0; i < gb.len(); i++) title_gb[8*i +: 8] = gb[i];
        load_rom(gb);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // title-only, matching title: 13 reads
        run_seq(1'b1, 1'b0, title_gb, 13*P, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0);
        // title-only, byte 2 wrong: aborts after 3 reads
        rom[2] = "X";
        run_seq(1'b1, 1'b0, title_gb, 3*P, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 0);
        // title-only, last title byte wrong
        load_rom(gb);
        rom[12] = "Q";
        run_seq(1'b1, 1'b0, title_gb, 13*P, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 0);
        // checksum-only over an all-zero header
        load_rom("");
        rom[25] = 8'hE7;
        run_seq(1'b0, 1'b1, title_gb, 26*P, 1'b1, 1'b0, 1'b0, 1'b1, 8'hE7, 0, 0);
        rom[25] = 8'hE6;
        run_seq(1'b0, 1'b1, title_gb, 26*P, 1'b0, 1'b0, 1'b1, 1'b1, 8'hE7, 0, 0);
        // both enabled, title wrong from byte 0, checksum good
        rom[25] = 8'hE7;
        run_seq(1'b1, 1'b1, title_gb, 26*P, 1'b0, 1'b1, 1'b0, 1'b1, 8'hE7, 0, 0);
        // both disabled: immediate pass
        run_seq(1'b0, 1'b0, title_gb, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0);
        // mixed header contents, both checks
        load_rom(gb);
        rom[20] = 8'h5A;
        rom[25] = 8'h10;
        run_seq(1'b1, 1'b1, title_gb, 26*P, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0);

        // reset during the wait of byte 5, request held high through release
        load_rom("");
        rom[25] = 8'hE7;
        run_seq(1'b0, 1'b1, title_gb, -10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 5*P + 10);
        @(negedge clk);
        s_mode = 2;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        ifc.verification_req = 1'b0;
        @(negedge clk);
        run_seq(1'b0, 1'b1, title_gb, 26*P, 1'b1, 1'b0, 1'b0, 1'b1, 8'hE7, 0, 0);

        // request edge during WAIT must be ignored
        load_rom(gb);
        run_seq(1'b1, 1'b0, title_gb, 13*P, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1, 0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cart_header_checker.md
CART_HEADER_CHECKER -- requirements
Module: cart_header_checker

Interface
REQ-001 Parameter TITLE_LEN, default 13, number of title bytes compared (1..16).
REQ-002 Parameter READ_WAIT, default 63, wait cycles per byte read (1..255).
REQ-003 Parameter HEADER_BASE, default 16'h0134, address of first header byte.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 verification_req  input  1  start request; rising edge significant.
REQ-007 check_title  input  1  enable title comparison; sampled on accepted request.
REQ-008 check_checksum  input  1  enable header checksum check; sampled on accepted request.
REQ-009 expected_title  input  128  expected title; byte i at bits [8i+7:8i]; sampled on accepted request.
REQ-010 cart_data  input  8  cartridge read data.
REQ-011 cart_rd  output  1  cartridge read strobe.
REQ-012 cart_addr  output  16  cartridge read address.
REQ-013 verifying  output  1  high while a check sequence runs.
REQ-014 verification_complete  output  1  high when result valid.
REQ-015 verification_passed  output  1  high when all enabled checks passed.
REQ-016 title_mismatch  output  1  a title byte differed.
REQ-017 checksum_mismatch  output  1  computed checksum differed from byte at HEADER_BASE+25.
REQ-018 computed_checksum  output  8  running/final checksum value.

Function
REQ-019 States: IDLE, READ, WAIT, DONE; verifying SHALL equal (state==READ or state==WAIT).
REQ-020 Request accepted only on rising edge of verification_req (registered previous value) in IDLE or DONE; ignored in READ/WAIT.
REQ-021 On acceptance: clear complete, passed, both mismatch flags, computed_checksum, byte offset; latch modes and expected_title; go READ.
REQ-022 Acceptance with both modes disabled: go DONE directly, passed=1, no cart read.
REQ-023 READ (1 cycle): cart_addr=HEADER_BASE+offset, cart_rd=1, wait counter=READ_WAIT; go WAIT.
REQ-024 WAIT: decrement counter each cycle; when counter==0 sample cart_data, offset+1; per-byte period = READ_WAIT+2 cycles.
REQ-025 Last offset: 25 if checksum enabled, else TITLE_LEN-1.
REQ-026 Title compare at offsets 0..TITLE_LEN-1 when enabled; mismatch sets title_mismatch.
REQ-027 Title-only mode: first mismatch goes DONE immediately (early abort); checksum mode: sequence always reads through offset 25.
REQ-028 Checksum: for offsets 0..24, computed_checksum <= computed_checksum - cart_data - 1, mod 256; at offset 25 compare, set checksum_mismatch if unequal.
REQ-029 After last offset sampled: go DONE.
REQ-030 DONE: complete=1, cart_rd=0, passed = not title_mismatch and not checksum_mismatch; held until next accepted request.
REQ-031 cart_rd SHALL stay 1 continuously from first READ until DONE entry.
REQ-032 cart_addr 16-bit add, no wrap checking; HEADER_BASE+25 SHALL not exceed 16'hFFFF.
REQ-033 Offset counter width 5 bits; counter width 8 bits.

Reset
REQ-034 Reset asserted SHALL immediately force IDLE; cart_rd=0, cart_addr=0, complete=0, passed=0, both mismatch flags=0, computed_checksum=0, offset=0, request-edge register=0.
REQ-035 Reset mid-sequence aborts with no result; verification_req held high through reset release SHALL not start a check (edge required).

Verification
REQ-036 Title-only, cart returns "GAMEBOYCAMERA" at 0x134.., READ_WAIT=63 -> 13 reads, complete after 13*65 cycles + 1, passed=1.
REQ-037 Title-only, byte 2 = "X" -> abort after 3rd read, complete=1, passed=0, title_mismatch=1, cart_rd=0.
REQ-038 Checksum-only, header bytes 0..24 all 0x00, byte 25=0xE7 -> computed_checksum=0xE7, passed=1; byte 25=0xE6 -> checksum_mismatch=1, passed=0.
REQ-039 Both enabled, title mismatch at byte 0 -> all 26 bytes read, title_mismatch=1, checksum valid, passed=0.
REQ-040 Reset asserted during WAIT of byte 5 -> outputs zero within same cycle; req held high after release -> stays IDLE; req low then high -> sequence restarts at offset 0.
REQ-041 Second rising edge in DONE -> complete drops next cycle, new sequence runs; req edge during WAIT -> ignored.
